// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the MEM-stage load/store interface.
//
// This block accepts one request at a time on a valid/ready channel. It
// waits WAIT_CYCLES extra cycles and then performs a byte, half or word
// access on an internal word-wide array. Load data and an error flag come
// back on a valid/ready response channel.
//
// Ports:
//   clk          clock
//   resetn       asynchronous active-low reset
//   req_valid    request present
//   req_ready    responder can accept a request (high only in IDLE)
//   req_we       1 = store, 0 = load
//   req_addr     byte address
//   req_size     0 = byte, 1 = half, 2 = word, 3 = reserved (faults)
//   req_unsigned loads: zero-extend when 1, sign-extend when 0
//   req_wdata    store data, right-aligned
//   rsp_valid    response present (high only in RESP)
//   rsp_ready    consumer accepts the response
//   rsp_rdata    extended load data; 0 for stores and faulted accesses
//   rsp_err      access faulted (out of range, reserved size, misaligned trap)
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses fault.
//                          When undefined, the low offset bits are forced to
//                          alignment and the access proceeds.
module dmem_responder #(
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt;

    // Request fields captured at the handshake
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH];

    // Access datapath
    logic             acc_fire;
    logic             a_we;
    logic             a_unsigned;
    logic [31:0]      a_addr;
    logic [1:0]       a_size;
    logic [31:0]      a_wdata;
    logic [31:0]      off;
    logic             in_range;
    logic             misalign;
    logic             acc_err;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wd_lane;
    logic [31:0]      rd_ext;

    // Shift the selected lanes down to bit 0 and extend them to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  ln,
                                                input logic [1:0]  sz,
                                                input logic        uns);
        logic [31:0] s;
        s = word >> {ln, 3'b000};
        case (sz)
            2'd0:    load_extend = uns ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'd1:    load_extend = uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: load_extend = s;
        endcase
    endfunction

    // With no wait states, the access happens on the accepting edge, so it
    // uses the live request. Otherwise it uses the captured copy.
    always_comb begin
        if (state == IDLE) begin
            a_we       = req_we;
            a_addr     = req_addr;
            a_size     = req_size;
            a_unsigned = req_unsigned;
            a_wdata    = req_wdata;
        end else begin
            a_we       = lat_we;
            a_addr     = lat_addr;
            a_size     = lat_size;
            a_unsigned = lat_unsigned;
            a_wdata    = lat_wdata;
        end
    end

    always_comb begin
        // Addresses below BASE_ADDR wrap to large offsets and fail the range test.
        off      = a_addr - BASE_ADDR;
        in_range = (off[31:ADDR_W] == '0);
        idx      = off[ADDR_W-1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((a_size == 2'd1) && a_addr[0]) ||
                   ((a_size == 2'd2) && (a_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        // Force alignment. When the trap is enabled, misaligned cases fault anyway.
        case (a_size)
            2'd0:    lane = a_addr[1:0];
            2'd1:    lane = {a_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
        case (a_size)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = 4'b0011 << lane;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        acc_err = !in_range || (a_size == 2'd3) || misalign;
        wd_lane = a_wdata << {lane, 3'b000};
        rd_ext  = load_extend(mem[idx], lane, a_size, a_unsigned);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        acc_fire  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        acc_fire  = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    acc_fire  = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) cnt <= 4'(WAIT_CYCLES);
            else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (acc_fire) begin
                rsp_rdata <= (acc_err || a_we) ? 32'd0 : rd_ext;
                rsp_err   <= acc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            lat_we       <= req_we;
            lat_addr     <= req_addr;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
        end
    end

    // Stores commit only on the access edge. While reset is held, nothing is written.
    always_ff @(posedge clk) begin
        if (resetn && acc_fire && a_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd_lane[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int          WC   = 1;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int          SPAN = 4096;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] mb [SPAN];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(WC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: little-endian, n = 2^size bytes from the aligned start.
    function automatic void model_access(input bit we, input logic [31:0] addr,
                                         input logic [1:0] size, input bit uns,
                                         input logic [31:0] wd,
                                         output logic [31:0] rd, output bit err);
        longint off;
        int n, bo;
        rd  = '0;
        err = 1'b0;
        off = longint'(addr) - longint'(BASE);
        if (size == 2'd3 || off < 0 || off >= SPAN) err = 1'b1;
        n = 1 << size;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (size != 2'd3 && (addr % n) != 0) err = 1'b1;
`endif
        if (err) return;
        bo = int'(off) - (int'(off) % n);
        for (int i = 0; i < n; i++) begin
            if (we) mb[bo+i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mb[bo+i];
        end
        if (!we && !uns && rd[8*n-1]) begin
            for (int b = 8*n; b < 32; b++) rd[b] = 1'b1;
        end
        if (we) rd = '0;
    endfunction

    task automatic xact(input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wd, input int hold,
                        output logic [31:0] got, output logic got_err);
        logic [31:0] erd;
        bit eerr;
        int n;
        model_access(we, addr, size, uns, wd, erd, eerr);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("req_ready_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", 32'(n), 32'(WC + 1));
        chk("rdata", rsp_rdata, erd);
        chk("err", 32'(rsp_err), 32'(eerr));
        got = rsp_rdata;
        got_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, erd);
            chk("hold_err", 32'(rsp_err), 32'(eerr));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_cleared", 32'(rsp_valid), 32'd0);
        chk("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        logic [31:0] a;
        logic [1:0]  sz;
        int          sel;

        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;

        // Fill the array so every later load has known contents.
        for (int i = 0; i < SPAN/4; i++)
            xact(1'b1, BASE + 32'(4*i), 2'd2, 1'b0, $urandom, 0, r, e);

        xact(1'b1, 32'h2004, 2'd2, 1'b0, 32'hDEADBEEF, 0, r, e);
        xact(1'b0, 32'h2004, 2'd2, 1'b0, 32'h0, 0, r, e);
        chk("lw_deadbeef", r, 32'hDEADBEEF);

        xact(1'b1, 32'h2004, 2'd2, 1'b0, 32'h11223344, 0, r, e);
        xact(1'b1, 32'h2005, 2'd0, 1'b0, 32'hAAAAAA80, 0, r, e);
        xact(1'b0, 32'h2004, 2'd2, 1'b0, 32'h0, 0, r, e);
        chk("sb_merge", r, 32'h11228044);
        xact(1'b0, 32'h2005, 2'd0, 1'b0, 32'h0, 0, r, e);
        chk("lb_sext", r, 32'hFFFFFF80);
        xact(1'b0, 32'h2005, 2'd0, 1'b1, 32'h0, 0, r, e);
        chk("lbu_zext", r, 32'h00000080);
        xact(1'b0, 32'h2006, 2'd1, 1'b0, 32'h0, 0, r, e);
        chk("lh_sext", r, 32'h00001122);

        xact(1'b0, 32'h2004, 2'd2, 1'b0, 32'h0, 5, r, e);
        chk("backpressure_rdata", r, 32'h11228044);

        xact(1'b1, 32'h1FFC, 2'd2, 1'b0, 32'hCAFEF00D, 0, r, e);
        chk("oor_low_err", 32'(e), 32'd1);
        xact(1'b1, 32'h3000, 2'd2, 1'b0, 32'hCAFEF00D, 0, r, e);
        chk("oor_high_err", 32'(e), 32'd1);
        xact(1'b0, 32'h2FFC, 2'd2, 1'b0, 32'h0, 0, r, e);
        chk("top_word_err", 32'(e), 32'd0);
        xact(1'b0, 32'h2004, 2'd3, 1'b0, 32'h0, 0, r, e);
        chk("size3_err", 32'(e), 32'd1);
        chk("size3_rdata", r, 32'd0);

        xact(1'b0, 32'h2006, 2'd2, 1'b0, 32'h0, 0, r, e);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misalign_err", 32'(e), 32'd1);
        chk("misalign_rdata", r, 32'd0);
`else
        chk("misalign_err", 32'(e), 32'd0);
        chk("misalign_rdata", r, 32'h11228044);
`endif

        // Reset during WAIT of a store must leave memory unchanged.
        xact(1'b1, 32'h2010, 2'd2, 1'b0, 32'h01020304, 0, r, e);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2010; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("in_wait_req_ready", 32'(req_ready), 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rdata", rsp_rdata, 32'd0);
        chk("arst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        xact(1'b0, 32'h2010, 2'd2, 1'b0, 32'h0, 0, r, e);
        chk("aborted_store", r, 32'h01020304);

        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom % 10);
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = BASE - 32'd8 + 32'($urandom % 16);
            else if (sel == 2) a = BASE + 32'(SPAN) - 32'd8 + 32'($urandom % 16);
            else               a = BASE + 32'($urandom % SPAN);
            sz = 2'($urandom % 4);
            xact(1'($urandom), a, sz, 1'($urandom), $urandom, int'($urandom % 3), r, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
